ring_pattern_checker: RTL

Receive-side checker for the 6-bit rotating one-hot pattern produced by the team's ring shift-left register. Samples the parallel ring word each cycle it is valid, verifies single-bit occupancy and correct rotate-left succession, and reports the decoded bit position. After a programmable number of consecutive correct words it reports lock, then flags and counts every break in the sequence. Sits downstream of the ring generator as a link and self-test monitor.

---
 rtl/ring_pattern_checker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ring_pattern_checker.sv
// Receive-side checker for a rotating one-hot ring word: decodes position, tracks lock, counts breaks.
// Optional sticky fault flag is built when RING_CHECK_STICKY_EN is defined.
module ring_pattern_checker #(
  parameter int WIDTH      = 6,
  parameter int LOCK_COUNT = 3,
  parameter int PW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [PW-1:0]    position,
  output logic             pos_valid,
  output logic             locked,
  output logic             error,
  output logic [7:0]       err_count,
  output logic             fault
);

  localparam int CW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    match_cnt_q, match_cnt_d;
  logic [PW-1:0]    position_q, position_d;
  logic             pos_valid_q, pos_valid_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [7:0]       err_count_q, err_count_d;

  logic             is_zero, is_onehot, is_bad, is_succ;
  logic [WIDTH-1:0] succ;
  logic [PW-1:0]    idx;

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  assign is_zero   = (in_data == '0);
  assign is_onehot = !is_zero && ((in_data & (in_data - WIDTH'(1))) == '0);
  assign is_bad    = !is_zero && !is_onehot;
  assign succ      = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign is_succ   = (in_data == succ);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (in_data[i]) idx = PW'(i);
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    position_d  = position_q;
    pos_valid_d = 1'b0;
    error_d     = 1'b0;
    err_count_d = err_count_q;
    if (in_valid) begin
      if (is_onehot) begin
        position_d  = idx;
        pos_valid_d = 1'b1;
        prev_d      = in_data;
      end
      unique case (state_q)
        SEARCH: begin
          if (is_onehot) begin
            match_cnt_d = CW'(1);
            state_d     = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (is_onehot) begin
            if (is_succ) begin
              match_cnt_d = match_cnt_q + CW'(1);
              if (match_cnt_q == CW'(LOCK_COUNT - 1)) state_d = LOCKED;
            end else begin
              match_cnt_d = CW'(1);
            end
          end else begin
            match_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
        LOCKED: begin
          if ((is_onehot && !is_succ) || is_bad) begin
            error_d     = 1'b1;
            match_cnt_d = '0;
            state_d     = SEARCH;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end else if (is_zero) begin
            // A generator reset drops lock without counting as a fault.
            match_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEARCH;
      prev_q      <= '0;
      match_cnt_q <= '0;
      position_q  <= '0;
      pos_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_cnt_q <= match_cnt_d;
      position_q  <= position_d;
      pos_valid_q <= pos_valid_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef RING_CHECK_STICKY_EN
  logic fault_q, fault_d;

  assign fault_d = fault_q | error_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign position  = position_q;
  assign pos_valid = pos_valid_q;
  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;

endmodule
